// File: rtl/dbg_port_pkg.sv
// Shared definitions for the Z80 debug port: FSM state encodings, status byte
// bit positions, default I/O addresses and the status byte packer.
package dbg_port_pkg;

  // Bus-side FSM states
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_STALL   = 2'd1;
  localparam logic [1:0] S_HOLD_WR = 2'd2;
  localparam logic [1:0] S_HOLD_RD = 2'd3;

  // Status byte bit positions (bits [4:0] carry the FIFO count)
  localparam int ST_OVF   = 7;
  localparam int ST_FULL  = 6;
  localparam int ST_EMPTY = 5;

  // Default low-address-byte decodes
  localparam logic [7:0] DEF_DATA_PORT   = 8'h01;
  localparam logic [7:0] DEF_STATUS_PORT = 8'h02;

  // Assemble the status byte returned to the CPU
  function automatic logic [7:0] pack_status(input logic       ovf,
                                             input logic       full,
                                             input logic       empty,
                                             input logic [4:0] cnt);
    logic [7:0] s;
    s           = 8'h00;
    s[ST_OVF]   = ovf;
    s[ST_FULL]  = full;
    s[ST_EMPTY] = empty;
    s[4:0]      = cnt;
    return s;
  endfunction

endpackage

// File: rtl/dbg_fifo.sv
// Synchronous byte FIFO for the debug port. Power-of-two depth, pointers wrap
// naturally, count spans 0..DEPTH. Push into a full FIFO and pop from an empty
// FIFO are ignored so the caller cannot corrupt pointer order.
module dbg_fifo #(
  parameter int DEPTH = 16,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst_L,
  input  logic          push,
  input  logic [7:0]    push_data,
  input  logic          pop,
  output logic [7:0]    head,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [7:0]    mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          push_ok_s;
  logic          pop_ok_s;

  assign full      = (count_r == CW'(DEPTH));
  assign empty     = (count_r == {CW{1'b0}});
  assign count     = count_r;
  assign head      = mem_r[rd_ptr_r];
  assign push_ok_s = push && !full;
  assign pop_ok_s  = pop && !empty;

  // Storage array: written at the tail on an accepted push
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointers and occupancy count
  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/z80_dbg_port.sv
// Z80 I/O-space debug port: OUT to DATA_PORT enqueues a byte, IN from
// STATUS_PORT returns {overflow, full, empty, count}. The buffer drains over a
// valid/ready stream. Optional macro DBG_PORT_WAIT_EN makes full-FIFO writes
// stall the CPU through WAIT_L; without it such writes are dropped and flagged
// as overflow. Exactly one push happens per I/O cycle because the FSM parks in
// HOLD_WR until IORQ_L returns high.
module z80_dbg_port
  import dbg_port_pkg::*;
#(
  parameter int         DEPTH       = 16,
  parameter logic [7:0] DATA_PORT   = DEF_DATA_PORT,
  parameter logic [7:0] STATUS_PORT = DEF_STATUS_PORT
) (
  input  logic        clk,
  input  logic        rst_L,
  input  logic [15:0] addr_bus,
  input  logic [7:0]  data_out,
  input  logic        IORQ_L,
  input  logic        RD_L,
  input  logic        WR_L,
  input  logic        M1_L,
  output logic [7:0]  data_in,
  output logic        data_drive,
  output logic        WAIT_L,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [1:0]    state_r;
  logic [1:0]    state_nxt_s;
  logic          ovf_r;
  logic          wait_r;
  logic          wait_nxt_s;
  logic          drive_r;
  logic          drive_nxt_s;
  logic [7:0]    din_r;
  logic [7:0]    din_nxt_s;
  logic          push_s;
  logic          ovf_set_s;
  logic          ovf_clr_s;
  logic          wr_strobe_s;
  logic          rd_strobe_s;
  logic          fifo_full_s;
  logic          fifo_empty_s;
  logic [CW-1:0] fifo_count_s;
  logic [7:0]    status_s;
  logic          unused_addr_s;

  // Only the low address byte is decoded on Z80 I/O cycles
  assign unused_addr_s = ^addr_bus[15:8];

  assign wr_strobe_s = !IORQ_L && !WR_L && M1_L && (addr_bus[7:0] == DATA_PORT);
  assign rd_strobe_s = !IORQ_L && !RD_L && M1_L && (addr_bus[7:0] == STATUS_PORT);
  assign status_s    = pack_status(ovf_r, fifo_full_s, fifo_empty_s, 5'(fifo_count_s));

  assign out_valid  = !fifo_empty_s;
  assign data_in    = din_r;
  assign data_drive = drive_r;
  // Without the stall option nothing ever clears wait_r, so WAIT_L stays high
  assign WAIT_L     = wait_r;

  dbg_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_L     (rst_L),
    .push      (push_s),
    .push_data (data_out),
    .pop       (out_valid && out_ready),
    .head      (out_data),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .count     (fifo_count_s)
  );

  // Bus FSM next-state, push request and registered-output next values
  always_comb begin
    state_nxt_s = state_r;
    wait_nxt_s  = wait_r;
    drive_nxt_s = drive_r;
    din_nxt_s   = din_r;
    push_s      = 1'b0;
    ovf_set_s   = 1'b0;
    ovf_clr_s   = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (wr_strobe_s) begin
          if (!fifo_full_s) begin
            push_s      = 1'b1;
            state_nxt_s = S_HOLD_WR;
          end else begin
`ifdef DBG_PORT_WAIT_EN
            wait_nxt_s  = 1'b0;
            state_nxt_s = S_STALL;
`else
            ovf_set_s   = 1'b1;
            state_nxt_s = S_HOLD_WR;
`endif
          end
        end else if (rd_strobe_s) begin
          din_nxt_s   = status_s;
          drive_nxt_s = 1'b1;
          state_nxt_s = S_HOLD_RD;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_STALL: begin
`ifdef DBG_PORT_WAIT_EN
        // Byte is taken from the bus at the push edge, not at stall entry
        if (!fifo_full_s) begin
          push_s      = 1'b1;
          wait_nxt_s  = 1'b1;
          state_nxt_s = S_HOLD_WR;
        end else begin
          state_nxt_s = S_STALL;
        end
`else
        wait_nxt_s  = 1'b1;
        state_nxt_s = S_IDLE;
`endif
      end
      S_HOLD_WR: begin
        if (IORQ_L) begin
          state_nxt_s = S_IDLE;
        end else begin
          state_nxt_s = S_HOLD_WR;
        end
      end
      S_HOLD_RD: begin
        if (IORQ_L) begin
          drive_nxt_s = 1'b0;
          din_nxt_s   = 8'h00;
          ovf_clr_s   = 1'b1;
          state_nxt_s = S_IDLE;
        end else begin
          state_nxt_s = S_HOLD_RD;
        end
      end
      default: begin
        wait_nxt_s  = 1'b1;
        drive_nxt_s = 1'b0;
        din_nxt_s   = 8'h00;
        state_nxt_s = S_IDLE;
      end
    endcase
  end

  // State, bus outputs and sticky overflow flag
  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      state_r <= S_IDLE;
      wait_r  <= 1'b1;
      drive_r <= 1'b0;
      din_r   <= 8'h00;
      ovf_r   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      wait_r  <= wait_nxt_s;
      drive_r <= drive_nxt_s;
      din_r   <= din_nxt_s;
      if (ovf_set_s) begin
        ovf_r <= 1'b1;
      end else if (ovf_clr_s) begin
        ovf_r <= 1'b0;
      end else begin
        ovf_r <= ovf_r;
      end
    end
  end

endmodule

// File: tb/tb_z80_dbg_port.sv
// Directed bench for z80_dbg_port. Expectations follow the build: with
// DBG_PORT_WAIT_EN defined the full-FIFO write stalls, otherwise it overflows.
module tb_z80_dbg_port;

  logic        clk;
  logic        rst_L;
  logic [15:0] addr_bus;
  logic [7:0]  data_out;
  logic        IORQ_L, RD_L, WR_L, M1_L;
  logic [7:0]  data_in;
  logic        data_drive;
  logic        WAIT_L;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;

  int vectors = 0;
  int miscompares = 0;

  z80_dbg_port dut (
    .clk        (clk),
    .rst_L      (rst_L),
    .addr_bus   (addr_bus),
    .data_out   (data_out),
    .IORQ_L     (IORQ_L),
    .RD_L       (RD_L),
    .WR_L       (WR_L),
    .M1_L       (M1_L),
    .data_in    (data_in),
    .data_drive (data_drive),
    .WAIT_L     (WAIT_L),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic io_write(input logic [15:0] a, input logic [7:0] d, input int hold);
    @(negedge clk);
    addr_bus = a; data_out = d; IORQ_L = 1'b0; WR_L = 1'b0;
    repeat (hold) @(negedge clk);
    IORQ_L = 1'b1; WR_L = 1'b1;
    @(negedge clk);
  endtask

  task automatic read_status(input string tag, input logic [15:0] a, input logic [7:0] exp);
    @(negedge clk);
    addr_bus = a; IORQ_L = 1'b0; RD_L = 1'b0;
    @(negedge clk);
    check({tag, "_data"}, data_in, exp);
    check({tag, "_drive"}, {7'd0, data_drive}, 8'h01);
    IORQ_L = 1'b1; RD_L = 1'b1;
    @(negedge clk);
    check({tag, "_release"}, {data_in[7:1], data_drive}, 8'h00);
  endtask

  task automatic pop_one(input string tag, input logic [7:0] exp);
    @(negedge clk);
    check({tag, "_valid"}, {7'd0, out_valid}, 8'h01);
    check({tag, "_data"}, out_data, exp);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic fill16();
    for (int i = 0; i < 16; i++) begin
      io_write(16'h0001, 8'h10 + 8'(i), 1);
    end
  endtask

  initial begin
    rst_L = 1'b0; addr_bus = 16'h0000; data_out = 8'h00;
    IORQ_L = 1'b1; RD_L = 1'b1; WR_L = 1'b1; M1_L = 1'b1; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst_L = 1'b1;
    @(negedge clk);

    // Reset values
    check("rst_wait", {7'd0, WAIT_L}, 8'h01);
    check("rst_drive", {7'd0, data_drive}, 8'h00);
    check("rst_data_in", data_in, 8'h00);
    check("rst_valid", {7'd0, out_valid}, 8'h00);

    // Single write of 'A', out_valid after the push edge
    @(negedge clk);
    addr_bus = 16'h0001; data_out = 8'h41; IORQ_L = 1'b0; WR_L = 1'b0;
    check("w1_pre_valid", {7'd0, out_valid}, 8'h00);
    @(posedge clk); #1;
    check("w1_valid", {7'd0, out_valid}, 8'h01);
    check("w1_head", out_data, 8'h41);
    @(negedge clk);
    IORQ_L = 1'b1; WR_L = 1'b1;
    @(negedge clk);
    read_status("st_one", 16'h0002, 8'h01);
    pop_one("pop_41", 8'h41);
    read_status("st_empty", 16'h0002, 8'h20);

    // Stretched strobe: one push only
    io_write(16'h0001, 8'h5A, 10);
    read_status("st_stretch", 16'h0002, 8'h01);
    pop_one("pop_5a", 8'h5A);

    // Interrupt acknowledge on matching addresses is ignored
    @(negedge clk);
    addr_bus = 16'h0001; data_out = 8'hC3; M1_L = 1'b0; IORQ_L = 1'b0; WR_L = 1'b0;
    repeat (3) @(negedge clk);
    check("inta_drive", {7'd0, data_drive}, 8'h00);
    check("inta_wait", {7'd0, WAIT_L}, 8'h01);
    WR_L = 1'b1; RD_L = 1'b0; addr_bus = 16'h0002;
    repeat (2) @(negedge clk);
    check("inta_rd_drive", {7'd0, data_drive}, 8'h00);
    IORQ_L = 1'b1; RD_L = 1'b1; M1_L = 1'b1;
    @(negedge clk);
    check("inta_no_push", {7'd0, out_valid}, 8'h00);

    // Non-matching address ignored; upper address byte not decoded
    io_write(16'h0003, 8'hEE, 1);
    check("nomatch_no_push", {7'd0, out_valid}, 8'h00);
    io_write(16'hAB01, 8'h77, 1);
    read_status("st_hi_addr", 16'hCD02, 8'h01);
    pop_one("pop_77", 8'h77);

    // Fill to 16, then a 17th write
    fill16();
    read_status("st_full", 16'h0002, 8'h50);
`ifdef DBG_PORT_WAIT_EN
    @(negedge clk);
    addr_bus = 16'h0001; data_out = 8'h99; IORQ_L = 1'b0; WR_L = 1'b0;
    @(negedge clk);
    check("stall_wait_low", {7'd0, WAIT_L}, 8'h00);
    repeat (3) @(negedge clk);
    check("stall_wait_held", {7'd0, WAIT_L}, 8'h00);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("stall_after_pop", {7'd0, WAIT_L}, 8'h00);
    check("stall_new_head", out_data, 8'h11);
    @(negedge clk);
    check("stall_release", {7'd0, WAIT_L}, 8'h01);
    IORQ_L = 1'b1; WR_L = 1'b1;
    @(negedge clk);
    read_status("st_refull", 16'h0002, 8'h50);
    for (int i = 1; i < 16; i++) begin
      pop_one("drain", 8'h10 + 8'(i));
    end
    pop_one("drain_tail", 8'h99);
    read_status("st_drained", 16'h0002, 8'h20);

    // Reset during a stall releases WAIT_L at once and loses the byte
    fill16();
    @(negedge clk);
    addr_bus = 16'h0001; data_out = 8'hAA; IORQ_L = 1'b0; WR_L = 1'b0;
    @(negedge clk);
    check("rst_stall_low", {7'd0, WAIT_L}, 8'h00);
    #2 rst_L = 1'b0;
    #1;
    check("rst_stall_wait", {7'd0, WAIT_L}, 8'h01);
    check("rst_stall_valid", {7'd0, out_valid}, 8'h00);
    IORQ_L = 1'b1; WR_L = 1'b1;
    @(negedge clk);
    rst_L = 1'b1;
    @(negedge clk);
    read_status("st_after_rst", 16'h0002, 8'h20);
`else
    @(negedge clk);
    addr_bus = 16'h0001; data_out = 8'h99; IORQ_L = 1'b0; WR_L = 1'b0;
    repeat (3) @(negedge clk);
    check("ovf_wait_high", {7'd0, WAIT_L}, 8'h01);
    IORQ_L = 1'b1; WR_L = 1'b1;
    @(negedge clk);
    read_status("st_ovf", 16'h0002, 8'hD0);
    read_status("st_ovf_clr", 16'h0002, 8'h50);
    for (int i = 0; i < 16; i++) begin
      pop_one("drain", 8'h10 + 8'(i));
    end
    read_status("st_drained", 16'h0002, 8'h20);

    // Asynchronous reset during a held read drops the bus at once
    io_write(16'h0001, 8'h33, 1);
    @(negedge clk);
    addr_bus = 16'h0002; IORQ_L = 1'b0; RD_L = 1'b0;
    @(negedge clk);
    check("rd_hold_drive", {7'd0, data_drive}, 8'h01);
    #2 rst_L = 1'b0;
    #1;
    check("rst_rd_drive", {7'd0, data_drive}, 8'h00);
    check("rst_rd_data", data_in, 8'h00);
    check("rst_rd_valid", {7'd0, out_valid}, 8'h00);
    check("rst_rd_wait", {7'd0, WAIT_L}, 8'h01);
    IORQ_L = 1'b1; RD_L = 1'b1;
    @(negedge clk);
    rst_L = 1'b1;
    @(negedge clk);
    read_status("st_after_rst", 16'h0002, 8'h20);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/z80_dbg_port.md
# z80_dbg_port

I/O-space responder on the Z80 bus that accepts `OUT (DATA_PORT),A` bytes from the CPU and buffers them in a FIFO. A simulation monitor or downstream console consumes the buffer over a valid/ready stream. The block also answers `IN A,(STATUS_PORT)` with a status byte. It stalls the CPU through `WAIT_L` when the FIFO is full. It sits beside `memory` and `ports` on the shared bus and replaces ad-hoc address-watch loops in benches.

## Interface
- `DEPTH`, 16: FIFO entries. Power of two, 2..16.
- `DATA_PORT`, 8'h01: low address byte that selects enqueue on writes.
- `STATUS_PORT`, 8'h02: low address byte that selects status on reads.
- `clk` in 1: single clock. All logic is on posedge.
- `rst_L` in 1: asynchronous, active-low reset.
- `addr_bus` in 16: CPU address. Only bits [7:0] are decoded.
- `data_out` in 8: CPU write data (the CPU's `data_out`).
- `IORQ_L`, `RD_L`, `WR_L`, `M1_L` in 1 each: CPU strobes.
- `data_in` out 8: read data to the CPU. It is 8'h00 when not driving.
- `data_drive` out 1: high while this block owns `data_in`. Used for bus muxing.
- `WAIT_L` out 1: CPU wait request, active low.
- `out_data` out 8, `out_valid` out 1, `out_ready` in 1: drain stream.

## Operation
- Write strobe: `!IORQ_L && !WR_L && M1_L && addr_bus[7:0]==DATA_PORT`.
- Read strobe: `!IORQ_L && !RD_L && M1_L && addr_bus[7:0]==STATUS_PORT`.
- Interrupt acknowledge (`!M1_L && !IORQ_L`) and non-matching addresses are ignored. In these cases `data_drive`=0 and `WAIT_L`=1.
- FSM states: IDLE, STALL, HOLD_WR, HOLD_RD.
- IDLE, write strobe, FIFO not full: push `data_out`, then go to HOLD_WR.
- IDLE, write strobe, FIFO full: go to STALL and drive `WAIT_L`=0. Without the macro, see Configuration.
- STALL: on the first posedge where full=0, push the byte and go to HOLD_WR with `WAIT_L`=1. The write byte is re-sampled at push time.
- IDLE, read strobe: latch the status byte, set `data_drive`=1, go to HOLD_RD.
- HOLD_WR and HOLD_RD: stay until `IORQ_L` is high, then return to IDLE. Exiting HOLD_RD clears the overflow flag and drops `data_drive`.
- Exactly one push occurs per CPU I/O cycle, however long the strobe is held.
- Status byte: bit7 = overflow (sticky), bit6 = full, bit5 = empty, bits[4:0] = count (0..DEPTH).
- Drain: `out_valid` = !empty. `out_data` = head entry. A pop occurs when `out_valid && out_ready`.
- Push and pop in the same cycle leave count unchanged and keep pointer order intact.
- Read and write pointers wrap modulo DEPTH. Count is DEPTH+1 wide in value range, i.e. 0..DEPTH.

## Timing
- Reset values: `WAIT_L`=1, `data_drive`=0, `data_in`=0, `out_valid`=0, count=0, overflow=0, state IDLE.
- Asserting `rst_L` mid-stall releases `WAIT_L` immediately (asynchronously) and the byte is lost.
- Strobes are sampled at posedge. The push happens at the first posedge the write strobe is seen in IDLE. `out_valid` rises on the next cycle.
- `WAIT_L` is registered. It goes low at the posedge after the full write strobe is sampled, which lands inside the CPU's automatic I/O TW. It rises at the same posedge that performs the push.
- Full-to-not-full: a pop at edge N clears full. The STALL push happens at edge N+1. There is no push into a full FIFO in the same cycle as a pop.
- `data_in` is valid from the posedge after the read strobe is sampled until `IORQ_L` deasserts.

## Configuration
- `DBG_PORT_WAIT_EN` defined: full-FIFO writes stall the CPU as described above.
- `DBG_PORT_WAIT_EN` undefined:
  - `WAIT_L` is tied to 1 and the STALL state is removed.
  - A write to a full FIFO is dropped, sets overflow, and goes to HOLD_WR.

## Structure
- `dbg_port_pkg` holds:
  - the FSM state enum;
  - status bit-position localparams (`ST_OVF`=7, `ST_FULL`=6, `ST_EMPTY`=5);
  - default port address constants.
- Sub-module `dbg_fifo`: synchronous FIFO with push/pop/full/empty/count. The top level contains the bus decode, FSM and status logic.

## Test plan
- Reset, then write 8'h41 to port 01: `out_valid` rises one cycle after the push, `out_data`=8'h41, and the status read returns 8'h01.
- With `out_ready`=0, write 17 bytes: the 17th write holds `WAIT_L`=0. Raising `out_ready` for one cycle pops entry 0, `WAIT_L` returns to 1, and the 17th byte lands at the tail. Count reads 16.
- Without the macro, repeat the 17-write case: `WAIT_L` stays 1. Status reads 8'hD0, then 8'h50 on the next read (overflow cleared).
- Stretch one write strobe for 10 cycles: exactly one push occurs (count=1).
- Interrupt acknowledge cycle with `addr_bus`=16'h0001: no push, `data_drive`=0.
- Assert `rst_L` low during STALL: `WAIT_L` goes to 1 within the same timestep, and count=0 after release.
